// File: rtl/pixel_block_loader_if.sv
// Pixel stream in, assembled 8x8 block of IEEE-754 singles out.
// The master modport drives pixels (producer side). The slave modport is the loader.
interface pixel_block_loader_if;
  logic [7:0]    pixel;
  logic          validin;
  logic          blockstart;
  logic [2047:0] matrix;
  logic          validout;
  logic          blockerr;

  modport master (
    output pixel, validin, blockstart,
    input  matrix, validout, blockerr
  );

  modport slave (
    input  pixel, validin, blockstart,
    output matrix, validout, blockerr
  );
endinterface

// File: rtl/pixel_block_loader.sv
// pixel_block_loader: collects 64 raster-order 8-bit pixels into an 8x8 matrix
// of IEEE-754 single-precision words through a two-stage pipeline.
// Stage E0 converts the pixel and assigns its index.
// Stage E1 writes the fill buffer and publishes each complete block.
// Optional macro LEVEL_SHIFT_EN: converts pixel-128 (signed) instead of pixel.
module pixel_block_loader (
  input  logic                 clk,
  input  logic                 rst_n,
  pixel_block_loader_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Integer-to-float conversion (exact: magnitudes never exceed 8 bits)
  // ---------------------------------------------------------------------------
  logic        sign;
  logic [7:0]  mag;
  logic [2:0]  msb;
  logic [22:0] mantissa;
  logic [31:0] word;

`ifdef LEVEL_SHIFT_EN
  logic [8:0] shifted;
  logic [7:0] negated;
  assign shifted = {1'b0, bus.pixel} - 9'd128;
  // Two's-complement magnitude; -128 yields 8'h80, which still fits.
  assign negated = ~shifted[7:0] + 8'd1;
  assign sign    = shifted[8];
  assign mag     = shifted[8] ? negated : shifted[7:0];
`else
  assign sign = 1'b0;
  assign mag  = bus.pixel;
`endif

  // Locate the leading one, then shift it out above bit 22 to leave the fraction.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    msb = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (mag[i]) msb = 3'(i);
    end
    mantissa = {mag, 15'd0} << (4'd8 - {1'b0, msb});
    if (mag == 8'd0) word = 32'h0000_0000;
    else             word = {sign, 8'd127 + {5'd0, msb}, mantissa};
  end

  // ---------------------------------------------------------------------------
  // Stage E0: accept pixel, assign index, register converted word
  // ---------------------------------------------------------------------------
  logic [5:0]  count;
  logic [5:0]  idx;
  logic        s1_valid;
  logic [5:0]  s1_idx;
  logic [31:0] s1_data;
  logic        blockerr_q;

  // A blockstart forces index 0, which abandons any block in progress.
  assign idx = bus.blockstart ? 6'd0 : count;

  // Sample the pixel, advance the element counter, flag abandoned partial blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      count      <= 6'd0;
      s1_valid   <= 1'b0;
      s1_idx     <= 6'd0;
      s1_data    <= 32'h0;
      blockerr_q <= 1'b0;
    end else begin
      s1_valid   <= bus.validin;
      blockerr_q <= bus.validin && bus.blockstart && (count != 6'd0);
      if (bus.validin) begin
        s1_idx  <= idx;
        s1_data <= word;
        count   <= idx + 6'd1;  // wraps 63 -> 0
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage E1: fill buffer write and block publication
  // ---------------------------------------------------------------------------
  logic [63:0][31:0] fill;
  logic [2047:0]     matrix_q;
  logic              validout_q;

  // Write slot k. On slot 63, publish the block using the incoming word for that slot.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the fill buffer is reset here because it must read zero after reset; memories without that need stay unreset.
    if (!rst_n) begin
      fill       <= '0;
      matrix_q   <= '0;
      validout_q <= 1'b0;
    end else begin
      validout_q <= 1'b0;
      if (s1_valid) begin
        fill[s1_idx] <= s1_data;
        if (s1_idx == 6'd63) begin
          matrix_q   <= {s1_data, fill[62:0]};
          validout_q <= 1'b1;
        end
      end
    end
  end

  assign bus.matrix   = matrix_q;
  assign bus.validout = validout_q;
  assign bus.blockerr = blockerr_q;

endmodule

// File: tb/tb_pixel_block_loader.sv
// Directed self-checking bench for pixel_block_loader (either build of LEVEL_SHIFT_EN).
module tb_pixel_block_loader;

`ifdef LEVEL_SHIFT_EN
  localparam int          OFF     = 128;
  localparam logic [31:0] E_ZEROP = 32'hC300_0000;  // pixel 0   -> -128.0
  localparam logic [31:0] E_255   = 32'h42FE_0000;  // pixel 255 ->  127.0
  localparam logic [31:0] E_200   = 32'h4290_0000;  // pixel 200 ->   72.0
  localparam logic [31:0] E_100   = 32'hC1E0_0000;  // pixel 100 ->  -28.0
`else
  localparam int          OFF     = 0;
  localparam logic [31:0] E_ZEROP = 32'h0000_0000;  // 0.0
  localparam logic [31:0] E_255   = 32'h437F_0000;  // 255.0
  localparam logic [31:0] E_200   = 32'h4348_0000;  // 200.0
  localparam logic [31:0] E_100   = 32'h42C8_0000;  // 100.0
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pixel_block_loader_if bus ();

  pixel_block_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int vo_count = 0;
  int be_count = 0;
  int last_cycle = 0;
  int vo_cyc [$];
  logic [31:0] vo_e1 [$];
  logic [31:0] vo_e62 [$];
  logic [7:0] fwd [64];
  logic [7:0] rev [64];
  logic [7:0] blk [64];

  // Edge counter: at a falling edge it equals the number of rising edges so far.
  always @(posedge clk) cycle <= cycle + 1;

  // Record output pulses away from the active edge.
  always @(negedge clk) begin
    if (bus.validout === 1'b1) begin
      vo_count++;
      vo_cyc.push_back(cycle);
      vo_e1.push_back(bus.matrix[63:32]);
      vo_e62.push_back(bus.matrix[62*32 +: 32]);
    end
    if (bus.blockerr === 1'b1) be_count++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] elem(input int k);
    return bus.matrix[32*k +: 32];
  endfunction

  task automatic send(input logic [7:0] p, input logic bs);
    @(negedge clk);
    bus.pixel      = p;
    bus.validin    = 1'b1;
    bus.blockstart = bs;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.validin    = 1'b0;
      bus.blockstart = 1'b0;
    end
  endtask

  task automatic send_arr(input logic [7:0] a [64], input logic bs_first);
    for (int k = 0; k < 64; k++) send(a[k], (k == 0) && bs_first);
    last_cycle = cycle;
  endtask

  task automatic check_zero(input string tag);
    int bad = 0;
    for (int k = 0; k < 64; k++) if (elem(k) !== 32'h0) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin
      fwd[k] = 8'(k + OFF);
      rev[k] = 8'(63 - k + OFF);
    end
    rst_n          = 1'b0;
    bus.pixel      = 8'd0;
    bus.validin    = 1'b0;
    bus.blockstart = 1'b0;
    idle(3);
    check("reset validout", bus.validout, 1'b0);
    check("reset blockerr", bus.blockerr, 1'b0);
    check_zero("reset matrix");
    rst_n = 1'b1;

    // Block A: pixel k -> value k, blockstart at counter 0 is not an error.
    send_arr(fwd, 1'b1);
    idle(4);
    check("A validout count", vo_count, 1);
    check("A latency", vo_cyc[0], last_cycle + 2);
    check("A no blockerr", be_count, 0);
    check("A e0", elem(0), 32'h0000_0000);
    check("A e1", elem(1), 32'h3F80_0000);
    check("A e2", elem(2), 32'h4000_0000);
    check("A e10", elem(10), 32'h4120_0000);
    check("A e63", elem(63), 32'h427C_0000);
    idle(10);
    check("A hold e1", elem(1), 32'h3F80_0000);
    check("A hold count", vo_count, 1);

    // Block B: every value zero (pixel 128 in the level-shifted build).
    for (int k = 0; k < 64; k++) blk[k] = 8'(OFF);
    send_arr(blk, 1'b0);
    idle(4);
    check("B validout count", vo_count, 2);
    check_zero("B all zero");

    // Block C: extremes and mid values, rest 255.
    for (int k = 0; k < 64; k++) blk[k] = 8'd255;
    blk[0] = 8'd0;
    blk[2] = 8'd200;
    blk[3] = 8'd100;
    send_arr(blk, 1'b0);
    idle(4);
    check("C validout count", vo_count, 3);
    check("C e0 pixel0", elem(0), E_ZEROP);
    check("C e1 pixel255", elem(1), E_255);
    check("C e2 pixel200", elem(2), E_200);
    check("C e3 pixel100", elem(3), E_100);
    begin
      int bad = 0;
      for (int k = 4; k < 64; k++) if (elem(k) !== E_255) bad++;
      check("C e4..63 pixel255", bad, 0);
    end

    // Block D: 20-pixel partial, then a fresh block flagged by blockstart.
    for (int k = 0; k < 20; k++) send(8'(9 + OFF), 1'b0);
    idle(3);
    check("D partial no validout", vo_count, 3);
    check("D partial no blockerr", be_count, 0);
    send_arr(fwd, 1'b1);
    idle(4);
    check("D blockerr once", be_count, 1);
    check("D validout once", vo_count, 4);
    check("D e0", elem(0), 32'h0000_0000);
    check("D e5", elem(5), 32'h40A0_0000);
    check("D e19", elem(19), 32'h4198_0000);
    check("D e20", elem(20), 32'h41A0_0000);

    // Block E: reset after 40 pixels, then a full new block.
    for (int k = 0; k < 40; k++) send(8'(200), 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.validin = 1'b0;
    idle(3);
    check_zero("E reset clears matrix");
    check("E reset validout", bus.validout, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 63; k++) send(rev[k], 1'b0);
    idle(4);
    check("E no early validout", vo_count, 4);
    send(rev[63], 1'b0);
    last_cycle = cycle;
    idle(4);
    check("E validout after 64th", vo_count, 5);
    check("E latency", vo_cyc[4], last_cycle + 2);
    check("E e0", elem(0), 32'h427C_0000);
    check("E e63", elem(63), 32'h0000_0000);

    // Block F/G: two blocks streamed with no gap; the second relies on counter wrap.
    send_arr(fwd, 1'b1);
    send_arr(rev, 1'b0);
    idle(4);
    check("FG validout count", vo_count, 7);
    check("FG spacing", vo_cyc[6] - vo_cyc[5], 64);
    check("G latency", vo_cyc[6], last_cycle + 2);
    check("F e1", vo_e1[5], 32'h3F80_0000);
    check("F e62", vo_e62[5], 32'h4278_0000);
    check("G e1", vo_e1[6], 32'h4278_0000);
    check("G e62", vo_e62[6], 32'h3F80_0000);
    check("FG no blockerr", be_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_block_loader.md
PIXEL_BLOCK_LOADER -- requirements
Module: pixel_block_loader

Interface
REQ-001 SHALL have: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: pixel  input  8  unsigned sample, raster order within the 8x8 block (row-major).
REQ-004 SHALL have: validin  input  1  pixel is valid this cycle.
REQ-005 SHALL have: blockstart  input  1  qualified by validin; marks element 0 of a new block.
REQ-006 SHALL have: matrix  output  2048  assembled block; element k=8*row+col at bits [32k+31:32k]; row r at [256r+255:256r].
REQ-007 SHALL have: validout  output  1  one-cycle pulse; matrix holds a new complete block.
REQ-008 SHALL have: blockerr  output  1  one-cycle pulse; a partial block was discarded.

Function
REQ-009 SHALL convert each accepted pixel to an IEEE-754 single-precision value: sign, biased exponent, 23-bit mantissa, exact (integers at most 255 need no rounding).
REQ-010 SHALL encode value 0 as 32'h00000000; no negative zero, denormals, Inf or NaN are ever produced.
REQ-011 SHALL use a two-stage pipeline. Edge E0 samples a pixel with validin=1 and registers the converted word and index k. Edge E1 writes that word into fill-buffer slot k.
REQ-012 SHALL keep a 6-bit element counter: reset value 0; increments on each accepted pixel; wraps 63 -> 0.
REQ-013 SHALL, at edge E1 for k=63, load the matrix register with all 64 fill-buffer words, including slot 63 written at that same edge. validout is 1 for exactly the following cycle. Latency: 2 edges from sampling the 64th pixel to validout high.
REQ-014 SHALL hold matrix stable between validout pulses; there is no back-pressure.
REQ-015 SHALL accept back-to-back pixels every cycle. Pixel 0 of the next block may be sampled at the same edge that loads the matrix register for the current block, with no loss.
REQ-016 SHALL ignore pixel and blockstart when validin=0; the counter holds.
REQ-017 SHALL, when validin=1 and blockstart=1, force that pixel to index 0. The counter becomes 1 after that edge.
REQ-018 SHALL pulse blockerr for one cycle, one edge after sampling, if blockstart arrives while the counter is not 0. Prior partial contents are discarded and never reach matrix.
REQ-019 SHALL leave fill-buffer slots not yet rewritten in the current block at stale values. Only complete 64-element blocks are ever published.

Reset
REQ-020 SHALL, on rst_n=0 (asynchronous, any cycle including mid-block), clear: counter, pipeline valid/index/data registers, fill buffer, matrix (all zero), validout=0, blockerr=0.
REQ-021 SHALL resume on the first rising edge after rst_n deasserts. A block in progress at reset is lost, and no validout is produced for it.

Configuration
REQ-022 SHALL support macro LEVEL_SHIFT_EN.
- Defined: the converted value is pixel-128 (signed, range -128..127).
- Undefined: the converted value is pixel (0..255, sign always 0).
- Latency and interface are identical in both builds.

Verification
REQ-023 SHALL pass these directed scenarios:
- LEVEL_SHIFT_EN, 64 pixels of 128 back-to-back -> validout pulse 2 edges after the last pixel; matrix all 32'h00000000.
- LEVEL_SHIFT_EN, pixel k = k+128 (k=0..63) -> element 1 = 32'h3F800000; element 63 = 32'h427C0000; element 0 = 0.
- LEVEL_SHIFT_EN, element 0 = 0, element 1 = 255 -> 32'hC3000000 and 32'h42FE0000 respectively.
- Without LEVEL_SHIFT_EN, all pixels 255 -> every element 32'h437F0000.
- 20 pixels, then blockstart with 64 new pixels -> blockerr once; exactly one validout; matrix contains only the new block.
- rst_n low after 40 pixels, then 64 pixels -> no validout before the new 64th pixel; one validout after it.
- Two blocks streamed with no gap -> two validout pulses exactly 64 cycles apart; both matrices correct.
